// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the 32x512 single-port SRAM macro controller.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry first-word-fall-through FIFO holding read data captured from the macro.
module sram_rsp_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry is presented directly; it only moves on pop, so data is stable under backpressure.
  assign valid = (count_q != 2'd0);
  assign data  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/sram_port0_ctrl.sv
// Request/response front end for port 0 of a single-port SRAM macro, with optional zero-fill after reset.
module sram_port0_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS    = DEF_NUM_WMASKS,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_busy,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [NUM_WMASKS-1:0] wmask_q;
  logic                  rd_p1;
  logic [1:0]            occ;
  logic [1:0]            used;
  logic                  pop;
  logic                  accept;
  logic                  in_init;

  // rst_n gates the combinational drive so the macro is deselected the instant reset asserts.
  assign in_init = rst_n && (state == ST_INIT);
  assign pop     = rsp_valid && rsp_ready;
  // A pop this cycle frees a slot in time for the read issued now, allowing one read per cycle.
  assign used      = occ + {1'b0, rd_p1} - {1'b0, pop};
  assign req_ready = rst_n && (state == ST_RUN) && (req_we || (used < 2'd2));
  assign accept    = req_valid && req_ready;
  assign init_busy = (state == ST_INIT);

  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = wmask_q;
    addr0  = addr_q;
    din0   = din_q;
    if (in_init) begin
      csb0   = 1'b0;
      web0   = 1'b0;
      wmask0 = '1;
      addr0  = init_cnt;
      din0   = '0;
    end else if (accept) begin
      csb0   = 1'b0;
      web0   = ~req_we;
      wmask0 = req_wmask;
      addr0  = req_addr;
      din0   = req_wdata;
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_cnt <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      wmask_q  <= '0;
      rd_p1    <= 1'b0;
    end else begin
      addr_q  <= addr0;
      din_q   <= din0;
      wmask_q <= wmask0;
      rd_p1   <= accept && !req_we;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (init_cnt == CNT_LAST) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // The macro presents read data one cycle after the request edge; capture it then.
  sram_rsp_fifo #(
    .DATA_W(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk      (clk0),
    .rst_n    (rst_n),
    .push     (rd_p1),
    .push_data(dout0),
    .pop      (pop),
    .valid    (rsp_valid),
    .data     (rsp_rdata),
    .count    (occ)
  );

endmodule
